// File: rtl/pic_lite.sv
// rtl/pic_lite.sv - simplified 8259-style programmable interrupt controller
module pic_lite #(
    parameter logic [7:0] VECTOR_BASE = 8'h08
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_irq,
    output logic       o_intr,
    input  logic       i_inta_n,
    input  logic       i_cs_n,
    input  logic       i_wr_n,
    input  logic       i_rd_n,
    input  logic       i_a0,
    input  logic [7:0] i_din,
    output logic [7:0] o_dout,
    output logic       o_dout_oe
);

    typedef enum logic {S_IDLE, S_VEC} state_t;

    state_t     r_state;
    logic [7:0] r_irq_q;
    logic [7:0] r_irr;
    logic [7:0] r_isr;
    logic [7:0] r_imr;
    logic [4:0] r_base;
    logic [2:0] r_vec_q;
    logic       r_wr_q;

    logic [7:0] w_elig;
    logic       w_elig_any;
    logic [2:0] w_win;
    logic [7:0] w_win_oh;
    logic [3:0] w_isr_low;
    logic [7:0] w_edge;
    logic       w_wr;
    logic       w_imr_wr;
    logic       w_init;
    logic       w_eoi;
    logic       w_ack;
    logic [7:0] w_irr_nxt;
    logic [7:0] w_isr_nxt;

    assign w_elig     = r_irr & ~r_imr;
    assign w_elig_any = |w_elig;
    assign w_edge     = i_irq & ~r_irq_q;

    // Lowest-index eligible request wins; lowest in-service bit (8 when none) blocks equal or lower priority
    always_comb begin
        w_win     = 3'd0;
        w_isr_low = 4'd8;
        for (int i = 7; i >= 0; i--) begin
            if (w_elig[i]) w_win = 3'(i);
            if (r_isr[i])  w_isr_low = 4'(i);
        end
    end

    assign w_win_oh = 8'b1 << w_win;
    assign o_intr   = w_elig_any && ({1'b0, w_win} < w_isr_low);

    // A write happens only on the first low cycle of the strobe
    assign w_wr     = ~i_cs_n & ~i_wr_n & r_wr_q;
    assign w_imr_wr = w_wr & i_a0;
    assign w_init   = w_wr & ~i_a0 & i_din[4];
    assign w_eoi    = w_wr & ~i_a0 & (i_din == 8'h20);
    assign w_ack    = (r_state == S_IDLE) & ~i_inta_n & w_elig_any;

    // EOI clears the old lowest in-service bit; ack sets the winner; new edges override the ack clear
    always_comb begin
        w_isr_nxt = w_eoi ? (r_isr & (r_isr - 8'd1)) : r_isr;
        w_irr_nxt = r_irr;
        if (w_ack) begin
            w_isr_nxt = w_isr_nxt | w_win_oh;
            w_irr_nxt = w_irr_nxt & ~w_win_oh;
        end
        w_irr_nxt = w_irr_nxt | w_edge;
    end

    // Request, service, mask and base registers; init write overrides every other update
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_irq_q <= 8'h00;
            r_irr   <= 8'h00;
            r_isr   <= 8'h00;
            r_imr   <= 8'hFF;
            r_base  <= VECTOR_BASE[7:3];
            r_wr_q  <= 1'b1;
        end else begin
            r_irq_q <= i_irq;
            r_wr_q  <= i_wr_n;
            if (w_init) begin
                r_base <= i_din[7:3];
                r_irr  <= 8'h00;
                r_isr  <= 8'h00;
                r_imr  <= 8'h00;
            end else begin
                r_irr <= w_irr_nxt;
                r_isr <= w_isr_nxt;
                if (w_imr_wr) r_imr <= i_din;
            end
        end
    end

    // Acknowledge FSM: freeze the vector on the first low inta_n cycle, hold it until inta_n rises
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
            r_vec_q <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!i_inta_n) begin
                        r_vec_q <= w_elig_any ? w_win : 3'd7;
                        r_state <= S_VEC;
                    end
                end
                S_VEC: begin
                    if (i_inta_n) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Output mux: acknowledge vector has priority over a register read
    always_comb begin
        o_dout    = 8'h00;
        o_dout_oe = 1'b0;
        if (r_state == S_VEC) begin
            o_dout    = {r_base, r_vec_q};
            o_dout_oe = ~i_inta_n;
        end else if (!i_cs_n && !i_rd_n) begin
            o_dout    = i_a0 ? r_imr : r_irr;
            o_dout_oe = 1'b1;
        end
    end

endmodule

// File: tb/tb_pic_lite.sv
// tb/tb_pic_lite.sv - self-checking bench for pic_lite
module tb_pic_lite;

    localparam logic [7:0] VB = 8'h08;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [7:0] i_irq;
    logic       o_intr;
    logic       i_inta_n;
    logic       i_cs_n;
    logic       i_wr_n;
    logic       i_rd_n;
    logic       i_a0;
    logic [7:0] i_din;
    logic [7:0] o_dout;
    logic       o_dout_oe;

    int tests = 0;
    int fails = 0;

    // reference model: sets of pending / in-service / masked lines
    logic [7:0] m_irr, m_isr, m_imr, m_prev_irq;
    logic [4:0] m_base;
    logic       m_prev_wr, m_invec;
    int         m_vec;

    pic_lite #(.VECTOR_BASE(VB)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_irq(i_irq), .o_intr(o_intr),
        .i_inta_n(i_inta_n), .i_cs_n(i_cs_n), .i_wr_n(i_wr_n), .i_rd_n(i_rd_n),
        .i_a0(i_a0), .i_din(i_din), .o_dout(o_dout), .o_dout_oe(o_dout_oe)
    );

    always #5 i_clk = ~i_clk;

    function automatic int lowest(logic [7:0] x);
        for (int i = 0; i < 8; i++) if (x[i]) return i;
        return 8;
    endfunction

    task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_irr = 8'h00; m_isr = 8'h00; m_imr = 8'hFF; m_prev_irq = 8'h00;
        m_base = VB[7:3]; m_prev_wr = 1'b1; m_invec = 1'b0; m_vec = 0;
    endtask

    task automatic model_edge();
        logic [7:0] e, n_irr, n_isr, n_imr, bit_w;
        logic [4:0] n_base;
        logic       wrs;
        e      = m_irr & ~m_imr;
        wrs    = !i_cs_n && !i_wr_n && m_prev_wr;
        n_irr  = m_irr; n_isr = m_isr; n_imr = m_imr; n_base = m_base;
        if (wrs && i_a0) n_imr = i_din;
        if (wrs && !i_a0 && i_din == 8'h20) n_isr = m_isr & (m_isr - 8'd1);
        if (!m_invec) begin
            if (!i_inta_n) begin
                m_invec = 1'b1;
                if (e != 0) begin
                    m_vec = lowest(e);
                    bit_w = 8'(1 << m_vec);
                    n_isr = n_isr | bit_w;
                    n_irr = n_irr & ~bit_w;
                end else begin
                    m_vec = 7;
                end
            end
        end else if (i_inta_n) begin
            m_invec = 1'b0;
        end
        n_irr = n_irr | (i_irq & ~m_prev_irq);
        if (wrs && !i_a0 && i_din[4]) begin
            n_base = i_din[7:3]; n_irr = 8'h00; n_isr = 8'h00; n_imr = 8'h00;
        end
        m_irr = n_irr; m_isr = n_isr; m_imr = n_imr; m_base = n_base;
        m_prev_irq = i_irq; m_prev_wr = i_wr_n;
    endtask

    task automatic check_outputs(string tag);
        logic [7:0] e, ed;
        logic       eintr, eoe;
        e     = m_irr & ~m_imr;
        eintr = (e != 0) && (lowest(e) < lowest(m_isr));
        ed = 8'h00; eoe = 1'b0;
        if (m_invec) begin
            ed = {m_base, 3'(m_vec)}; eoe = !i_inta_n;
        end else if (!i_cs_n && !i_rd_n) begin
            ed = i_a0 ? m_imr : m_irr; eoe = 1'b1;
        end
        check({tag, "_intr"}, {7'b0, o_intr}, {7'b0, eintr});
        check({tag, "_dout"}, o_dout, ed);
        check({tag, "_oe"}, {7'b0, o_dout_oe}, {7'b0, eoe});
    endtask

    task automatic tick();
        @(posedge i_clk);
        if (!i_rst) model_reset(); else model_edge();
        #1;
        check_outputs("cyc");
    endtask

    task automatic bus_write(logic a, logic [7:0] d);
        i_cs_n = 1'b0; i_wr_n = 1'b0; i_a0 = a; i_din = d;
        tick();
        i_cs_n = 1'b1; i_wr_n = 1'b1;
        tick();
    endtask

    task automatic bus_read(string tag, logic a, logic [7:0] exp);
        i_cs_n = 1'b0; i_rd_n = 1'b0; i_a0 = a;
        #1;
        check(tag, o_dout, exp);
        check({tag, "_oe"}, {7'b0, o_dout_oe}, 8'h01);
        check_outputs({tag, "_m"});
        i_cs_n = 1'b1; i_rd_n = 1'b1;
    endtask

    task automatic ack(string tag, logic [7:0] exp, int nlow);
        i_inta_n = 1'b0;
        tick();
        check(tag, o_dout, exp);
        check({tag, "_oe"}, {7'b0, o_dout_oe}, 8'h01);
        repeat (nlow - 1) tick();
        i_inta_n = 1'b1;
        tick();
    endtask

    initial begin
        int ack_left;
        int r;
        i_rst = 1'b0; i_irq = 8'h00; i_inta_n = 1'b1; i_cs_n = 1'b1;
        i_wr_n = 1'b1; i_rd_n = 1'b1; i_a0 = 1'b0; i_din = 8'h00;
        model_reset();
        #1;
        check("rst_intr", {7'b0, o_intr}, 8'h00);
        check("rst_oe", {7'b0, o_dout_oe}, 8'h00);
        check("rst_dout", o_dout, 8'h00);
        tick(); tick();
        i_rst = 1'b1;
        tick();

        // reset mask, unmask, single edge
        bus_read("imr_rst", 1'b1, 8'hFF);
        bus_write(1'b1, 8'h00);
        check("no_req_intr", {7'b0, o_intr}, 8'h00);
        i_irq = 8'h08;
        tick();
        check("irq3_intr", {7'b0, o_intr}, 8'h01);
        ack("vec3", 8'h0B, 2);
        bus_write(1'b0, 8'h20);

        // priority against in-service
        i_irq = 8'h24;
        tick();
        check("two_pend_intr", {7'b0, o_intr}, 8'h01);
        ack("vec2", 8'h0A, 2);
        check("blocked_intr", {7'b0, o_intr}, 8'h00);
        bus_write(1'b0, 8'h20);
        check("eoi_intr", {7'b0, o_intr}, 8'h01);
        ack("vec5", 8'h0D, 3);
        bus_write(1'b0, 8'h20);

        // init write
        bus_write(1'b0, 8'h70);
        bus_read("irr_init", 1'b0, 8'h00);
        check("init_intr", {7'b0, o_intr}, 8'h00);
        i_irq = 8'h00;
        tick();
        i_irq = 8'h01;
        tick();
        ack("vec0_base14", 8'h70, 2);
        bus_write(1'b0, 8'h20);

        // masked request
        bus_write(1'b1, 8'h02);
        i_irq = 8'h00;
        tick();
        i_irq = 8'h02;
        tick();
        bus_read("irr_masked", 1'b0, 8'h02);
        check("masked_intr", {7'b0, o_intr}, 8'h00);
        bus_write(1'b1, 8'h00);
        check("unmask_intr", {7'b0, o_intr}, 8'h01);
        ack("vec1", 8'h71, 2);
        bus_write(1'b0, 8'h20);

        // spurious and level-held
        ack("spurious", 8'h77, 2);
        check("spur_intr", {7'b0, o_intr}, 8'h00);
        i_irq = 8'h12;
        tick();
        ack("vec4", 8'h74, 2);
        bus_write(1'b0, 8'h20);
        ack("held_no_rereq", 8'h77, 2);

        // reset during the vector phase
        i_irq = 8'h00;
        tick();
        i_irq = 8'h80;
        tick();
        i_inta_n = 1'b0;
        tick();
        check("vec7_pre_rst", o_dout, 8'h77);
        i_rst = 1'b0;
        model_reset();
        #1;
        check("rst_vec_oe", {7'b0, o_dout_oe}, 8'h00);
        check("rst_vec_dout", o_dout, 8'h00);
        check("rst_vec_intr", {7'b0, o_intr}, 8'h00);
        i_inta_n = 1'b1;
        tick();
        i_rst = 1'b1;
        tick();
        bus_read("imr_rst2", 1'b1, 8'hFF);

        // randomized traffic against the model
        bus_write(1'b1, 8'h00);
        ack_left = 0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) i_irq = i_irq ^ (8'($urandom) & 8'($urandom));
            if (ack_left > 0) begin
                i_inta_n = 1'b0; ack_left--;
            end else if (!i_inta_n) begin
                i_inta_n = 1'b1;
            end else if ($urandom_range(0, 7) == 0) begin
                i_inta_n = 1'b0; ack_left = $urandom_range(1, 3);
            end
            i_cs_n = 1'b1; i_wr_n = 1'b1; i_rd_n = 1'b1;
            r = $urandom_range(0, 7);
            if (r == 0) begin
                i_cs_n = 1'b0; i_wr_n = 1'b0; i_a0 = 1'($urandom);
                if (i_a0) i_din = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
                else case ($urandom_range(0, 3))
                    0, 3: i_din = 8'h20;
                    1:    i_din = {5'($urandom), 3'b000} | 8'h10;
                    default: i_din = 8'($urandom);
                endcase
            end else if (r == 1) begin
                i_cs_n = 1'b0; i_rd_n = 1'b0; i_a0 = 1'($urandom);
            end
            #1;
            check_outputs("rnd_pre");
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pic_lite.md
# pic_lite

Simplified 8259-style programmable interrupt controller sitting directly upstream of the 8088 core's interrupt input. It collects eight edge-triggered requests, resolves fixed priority against an in-service register, drives `intr`, and answers the CPU's single `inta_n` acknowledge pulse by placing an 8-bit vector on a dedicated data output. Mask, vector base and EOI are programmed through a two-address I/O port decoded by the system glue.

## Interface

- `VECTOR_BASE`, default 8'h08: reset vector base; only bits [7:3] are used.

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `irq`  in  8  request lines; bit 0 is highest priority; rising edge requests.
- `intr`  out  1  interrupt request to the CPU.
- `inta_n`  in  1  CPU acknowledge, active low, one contiguous low pulse of ≥2 cycles.
- `cs_n`  in  1  chip select for register access.
- `wr_n`  in  1  I/O write strobe, active low.
- `rd_n`  in  1  I/O read strobe, active low.
- `a0`  in  1  register select.
- `din`  in  8  write data.
- `dout`  out  8  read data or vector.
- `dout_oe`  out  1  high while `dout` must be driven onto the CPU bus.

## Operation

- State: `irq_q[7:0]` (previous irq sample), IRR, ISR, IMR (8 bits each), `base[4:0]`, `vec_q[2:0]`, `wr_q` (previous `wr_n`), FSM `{IDLE, VEC}`.
- Edge detect: `irq[i] & ~irq_q[i]` sets IRR[i]. Level-held lines do not re-request.
- Eligible set `E = IRR & ~IMR`. Winner `w` = lowest-index bit of E. `intr = 1` iff E≠0 and (ISR = 0 or `w` < lowest-index set bit of ISR). `intr` is combinational from registered state only.
- Register write: a write occurs on the cycle where `~cs_n & ~wr_n & wr_q`, i.e. the first low cycle of the strobe. Only one write per strobe.
  - `a0=1`: IMR ← `din`.
  - `a0=0`, `din[4]=1` (init): `base` ← `din[7:3]`, IRR ← 0, ISR ← 0, IMR ← 8'h00.
  - `a0=0`, `din=8'h20` (EOI): clear the lowest-index set bit of ISR. No effect if ISR=0.
  - Any other `a0=0` value is ignored.
- Register read: while `~cs_n & ~rd_n`, `dout` = IRR when `a0=0`, IMR when `a0=1`, and `dout_oe=1`.
- Acknowledge FSM:
  - IDLE, `inta_n=0` sampled: if E≠0, `vec_q` ← `w`, ISR[w] ← 1, IRR[w] ← 0. If E=0 (spurious), `vec_q` ← 7 with no ISR/IRR change. Go to VEC.
  - VEC: `dout = {base, vec_q}`, `dout_oe = ~inta_n`. On `inta_n=1`, go to IDLE.
  - Winner is frozen at the first low cycle. Later requests do not alter `vec_q`.
- Precedence within one cycle:
  - New edge on bit i beats the acknowledge clear of IRR[i]; IRR[i] stays 1.
  - Init write beats everything.
  - EOI evaluates ISR before this cycle's acknowledge set; both updates apply.
  - `dout` mux: VEC vector has priority over register read.

## Timing

- Reset (async assert, values hold until first clock after deassert):
  - IRR=0, ISR=0, IMR=8'hFF, `base`=`VECTOR_BASE[7:3]`, `irq_q`=0, `wr_q`=1, FSM=IDLE.
  - Outputs: `intr=0`, `dout=8'h00`, `dout_oe=0`.
  - Reset mid-acknowledge returns to IDLE with no vector driven.
- `irq[i]` low at edge k−1 and high at edge k: IRR[i]=1 after edge k; `intr` high in cycle k+1 if enabled (1-edge latency).
- `inta_n` first sampled low at edge a: FSM=VEC and ISR updated after edge a. `intr` falls in the same cycle unless another higher-priority request remains.
- `dout`/`dout_oe` are valid during the second low cycle of `inta_n`, where the CPU latches the vector, and stay valid until `inta_n` rises.
- Register writes take effect at the edge of the first low `wr_n` cycle. `intr` reflects the new IMR one cycle later.

## Test plan

- Reset → `intr=0`, `dout_oe=0`, IMR read (`a0=1`) returns 8'hFF; write IMR=8'h00, pulse `irq[3]` → `intr=1` one cycle after the sampled edge.
- Pending `irq[5]` and `irq[2]`, 2-cycle `inta_n` pulse → `dout=8'h0A`, `dout_oe=1` in the second low cycle; ISR=8'h04; `intr` stays 0 until EOI 8'h20, then rises for bit 5 (vector 8'h0D on the next ack).
- Init write `din=8'h70` (`a0=0`) → base=14; `irq[0]` request and ack → vector 8'h70; IRR/ISR were cleared by the init.
- IMR=8'h02 with `irq[1]` edge → IRR=8'h02, `intr=0`; unmask with IMR=0 → `intr=1`.
- `inta_n` low with E=0 → vector `{base,3'd7}`, ISR unchanged. Hold `irq[4]` high across an ack → no second request.
- Assert `rst` during VEC → `dout_oe=0` immediately; state reset as listed.
